conv_line_feeder: RTL and testbench
===================================

Name: conv_line_feeder

Overview:
- Source side of the convolve datapath: holds one image tile and one 3x3 kernel.
- Answers the convolver's `shift_buffer` requests with successive 3-row columns on `in_l1`/`in_l2`/`in_l3`.
- Answers `kernel_addr` with `kernel_in`.
- Walks the tile row-band by row-band at the configured stride and flags row and frame completion to the controller.

Parameters:
- BIT_DEPTH, 8, pixel and weight width.
- IMG_W, 8, tile width in pixels (columns per row band).
- IMG_H, 8, tile height in pixels; must be >= 3.
- ADDR_W, 6, image write address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- img_wr_en  in  1  image load strobe
- img_wr_addr  in  ADDR_W  load address = row*IMG_W + col
- img_wr_data  in  BIT_DEPTH  load pixel
- kw_wr_en  in  1  kernel load strobe
- kw_wr_addr  in  4  kernel index 0..8, row-major
- kw_wr_data  in  BIT_DEPTH  kernel weight
- start  in  1  begin serving one frame
- stride  in  2  row/band stride; 1 or 2, any other value treated as 1
- shift_buffer  in  1  consumer takes current column, advance
- kernel_addr  in  4  kernel index requested by consumer
- in_l1  out  BIT_DEPTH  pixel at (row_base, col)
- in_l2  out  BIT_DEPTH  pixel at (row_base+1, col)
- in_l3  out  BIT_DEPTH  pixel at (row_base+2, col)
- kernel_in  out  BIT_DEPTH  weight[kernel_addr]
- busy  out  1  high in every state except IDLE
- row_done  out  1  one-cycle pulse when a row band is exhausted
- frame_done  out  1  one-cycle pulse when the last band is exhausted

Behaviour:
- Reset (synchronous, active-high):
  - state = IDLE, `row_base` = 0, `col` = 0.
  - `in_l1`/`in_l2`/`in_l3` = 0, `busy`/`row_done`/`frame_done` = 0.
  - All 9 kernel registers = 0.
  - Image memory is not cleared.
- Image load:
  - Accepted only in IDLE.
  - Writes to addresses >= IMG_W*IMG_H are dropped.
  - `img_wr_en` outside IDLE is ignored.
- Kernel load:
  - Accepted in any state; visible on `kernel_in` the cycle after the write.
  - `kw_wr_addr` > 8 is dropped.
- `kernel_in` is combinational from `kernel_addr` (same-cycle, so the consumer can multiply-accumulate with its registered address); `kernel_addr` > 8 gives 0.
- `in_l*` are registered, show-ahead: the current column is always presented and replaced the cycle after it is consumed.
- IDLE:
  - `start` latches stride as `s_q` (1 or 2), sets `row_base`=0 and `col`=0.
  - Loads column 0 of rows 0..2 into `in_l*`, then moves to SERVE.
  - `shift_buffer` is ignored.
- SERVE:
  - `shift_buffer`=1 with `col` < IMG_W-1: `col`++, and `in_l*` take column `col`+1 next cycle.
  - `shift_buffer`=1 with `col` = IMG_W-1: go to ROW_END; `in_l*` hold.
  - `start` is ignored.
- ROW_END (1 cycle):
  - `row_done`=1, `nb` = `row_base` + `s_q`.
  - If `nb`+2 <= IMG_H-1: `row_base`=`nb`, `col`=0, `in_l*` = column 0 of rows `nb`..`nb`+2, go to SERVE.
  - Otherwise go to FRAME_DONE.
  - `shift_buffer` is ignored.
- FRAME_DONE (1 cycle):
  - `frame_done`=1, `in_l*` cleared to 0, go to IDLE.
- Band counts: stride 1 gives IMG_H-2 bands; stride 2 gives floor((IMG_H-3)/2)+1 bands.
- Memory read address = r*IMG_W + c, three reads per update (rows r, r+1, r+2); unsigned arithmetic, no wrap (guaranteed by the band check).
- Simultaneous events:
  - `kw_wr_en` with a read of the same index: `kernel_in` returns the old value this cycle.
  - `start` and `img_wr_en` in the same IDLE cycle: the write completes and the prefetch sees the old data at that address.
- Reset mid-frame: returns to IDLE within one cycle; no `row_done`/`frame_done` pulse.

Decomposition:
- Shared package conv_pkg:
  - state encodings FEED_IDLE, FEED_SERVE, FEED_ROW_END, FEED_FRAME_DONE;
  - KERNEL_TAPS = 9;
  - STRIDE_1 = 2'd1, STRIDE_2 = 2'd2;
  - a stride normalisation function.
- One sub-module, conv_kernel_regs: 9 x BIT_DEPTH register file with synchronous write, combinational read, and out-of-range returning 0.
- The image array and FSM stay in conv_line_feeder.

Test Plan:
- Load img[r][c] = r*16+c (8x8), start with stride=1.
  - Next cycle: `in_l1`/`in_l2`/`in_l3` = 0x00/0x10/0x20, `busy`=1.
  - One shift later: 0x01/0x11/0x21.
- Stride 1, 8 shifts: `row_done` pulses once; the following SERVE cycle shows 0x10/0x20/0x30.
  - Total 6 `row_done` pulses, then `frame_done` one cycle after the 6th, then `busy`=0.
- Start with stride=2: bands start at rows 0, 2, 4.
  - After the first `row_done`, outputs are 0x20/0x30/0x40.
  - Exactly 3 `row_done` pulses, then `frame_done`.
  - Start with stride=3 behaves identically to stride=1.
- Kernel: write w[k]=k+1 for k=0..8.
  - `kernel_addr`=0 gives 1; `kernel_addr`=8 gives 9; `kernel_addr`=12 gives 0.
  - Rewrite w[4]=0x55 during SERVE: visible the next cycle.
- Assert `rst` mid-band (`col`=3):
  - Next cycle: `in_l*`=0, `busy`=0, no pulses.
  - Subsequent image load in IDLE is accepted; restart shows 0x00/0x10/0x20.
- Protocol checks:
  - `shift_buffer` held in IDLE: no state change.
  - `shift_buffer` during ROW_END: `col` stays 0.
  - `start` during SERVE: no restart.
  - `img_wr_en` during SERVE: image data is unchanged.

Source files
------------

// File: rtl/conv_pkg.sv
// conv_pkg: shared state encodings, constants and stride helper for the convolve datapath.
package conv_pkg;
   typedef enum logic [1:0] {FEED_IDLE, FEED_SERVE, FEED_ROW_END, FEED_FRAME_DONE} feed_state_e;
   localparam int KERNEL_TAPS = 9;
   localparam logic [1:0] STRIDE_1 = 2'd1;
   localparam logic [1:0] STRIDE_2 = 2'd2;
   function automatic logic [1:0] norm_stride(input logic [1:0] s);
      return (s == STRIDE_2) ? STRIDE_2 : STRIDE_1;
   endfunction
endpackage

// File: rtl/conv_kernel_regs.sv
// conv_kernel_regs: 3x3 weight register file, synchronous write, combinational read, out-of-range reads 0.
module conv_kernel_regs
   import conv_pkg::*;
#(
   parameter int BIT_DEPTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 wr_en_i,
   input  logic [3:0]           wr_addr_i,
   input  logic [BIT_DEPTH-1:0] wr_data_i,
   input  logic [3:0]           rd_addr_i,
   output logic [BIT_DEPTH-1:0] rd_data_o
);
   logic [BIT_DEPTH-1:0] w_q [KERNEL_TAPS];
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < KERNEL_TAPS; i++) w_q[i] <= '0;
      end else if (wr_en_i && wr_addr_i < 4'(KERNEL_TAPS)) begin
         w_q[wr_addr_i] <= wr_data_i;
      end
   end
   assign rd_data_o = (rd_addr_i < 4'(KERNEL_TAPS)) ? w_q[rd_addr_i] : '0;
endmodule

// File: rtl/conv_line_feeder.sv
// conv_line_feeder: tile + kernel store; serves 3-row columns band by band at the configured stride.
module conv_line_feeder
   import conv_pkg::*;
#(
   parameter int BIT_DEPTH = 8,
   parameter int IMG_W     = 8,
   parameter int IMG_H     = 8,
   parameter int ADDR_W    = 6
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 img_wr_en,
   input  logic [ADDR_W-1:0]    img_wr_addr,
   input  logic [BIT_DEPTH-1:0] img_wr_data,
   input  logic                 kw_wr_en,
   input  logic [3:0]           kw_wr_addr,
   input  logic [BIT_DEPTH-1:0] kw_wr_data,
   input  logic                 start,
   input  logic [1:0]           stride,
   input  logic                 shift_buffer,
   input  logic [3:0]           kernel_addr,
   output logic [BIT_DEPTH-1:0] in_l1,
   output logic [BIT_DEPTH-1:0] in_l2,
   output logic [BIT_DEPTH-1:0] in_l3,
   output logic [BIT_DEPTH-1:0] kernel_in,
   output logic                 busy,
   output logic                 row_done,
   output logic                 frame_done
);
   localparam int NPIX = IMG_W * IMG_H;
   localparam int RW   = $clog2(IMG_H + 3);
   localparam int CW   = $clog2(IMG_W + 1);
   function automatic logic [ADDR_W-1:0] addr(input int r, input int c);
      return ADDR_W'(r * IMG_W + c);
   endfunction
   feed_state_e          state_q;
   logic [RW-1:0]        row_base_q, nb, fr;
   logic [CW-1:0]        col_q, fc;
   logic [1:0]           s_q;
   logic [BIT_DEPTH-1:0] l1_q, l2_q, l3_q, p1_d, p2_d, p3_d;
   logic [BIT_DEPTH-1:0] mem [NPIX];
   logic                 band_ok, last_col;
   always_ff @(posedge clk) begin
      if (img_wr_en && state_q == FEED_IDLE && int'(img_wr_addr) < NPIX) mem[img_wr_addr] <= img_wr_data;
   end
   // Fetch target is the column that becomes current after this cycle's transition.
   always_comb begin
      nb       = row_base_q + RW'(s_q);
      band_ok  = int'(nb) + 2 <= IMG_H - 1;
      last_col = col_q == CW'(IMG_W - 1);
      fr       = (state_q == FEED_ROW_END && band_ok) ? nb : (state_q == FEED_IDLE ? '0 : row_base_q);
      fc       = (state_q == FEED_SERVE && !last_col) ? col_q + 1'b1 : '0;
      p1_d     = mem[addr(int'(fr), int'(fc))];
      p2_d     = mem[addr(int'(fr) + 1, int'(fc))];
      p3_d     = mem[addr(int'(fr) + 2, int'(fc))];
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= FEED_IDLE;
         row_base_q <= '0;
         col_q      <= '0;
         s_q        <= STRIDE_1;
         {l1_q, l2_q, l3_q} <= '0;
      end else begin
         case (state_q)
            FEED_IDLE: if (start) begin
               s_q        <= norm_stride(stride);
               row_base_q <= '0;
               col_q      <= '0;
               {l1_q, l2_q, l3_q} <= {p1_d, p2_d, p3_d};
               state_q    <= FEED_SERVE;
            end
            FEED_SERVE: if (shift_buffer) begin
               if (last_col) state_q <= FEED_ROW_END;
               else begin
                  col_q <= col_q + 1'b1;
                  {l1_q, l2_q, l3_q} <= {p1_d, p2_d, p3_d};
               end
            end
            FEED_ROW_END: if (band_ok) begin
               row_base_q <= nb;
               col_q      <= '0;
               {l1_q, l2_q, l3_q} <= {p1_d, p2_d, p3_d};
               state_q    <= FEED_SERVE;
            end else state_q <= FEED_FRAME_DONE;
            default: begin
               {l1_q, l2_q, l3_q} <= '0;
               state_q <= FEED_IDLE;
            end
         endcase
      end
   end
   conv_kernel_regs #(.BIT_DEPTH(BIT_DEPTH)) u_kregs (
      .clk(clk), .rst(rst), .wr_en_i(kw_wr_en), .wr_addr_i(kw_wr_addr), .wr_data_i(kw_wr_data),
      .rd_addr_i(kernel_addr), .rd_data_o(kernel_in)
   );
   assign in_l1      = l1_q;
   assign in_l2      = l2_q;
   assign in_l3      = l3_q;
   assign busy       = state_q != FEED_IDLE;
   assign row_done   = state_q == FEED_ROW_END;
   assign frame_done = state_q == FEED_FRAME_DONE;
endmodule

// File: tb/tb_conv_line_feeder.sv
// tb_conv_line_feeder: kernel vector table plus scoreboarded frame walks and reset/protocol sequences.
module tb_conv_line_feeder;
   logic clk = 1'b0;
   logic rst, img_wr_en, kw_wr_en, start, shift_buffer;
   logic [5:0] img_wr_addr;
   logic [7:0] img_wr_data, kw_wr_data, in_l1, in_l2, in_l3, kernel_in;
   logic [3:0] kw_wr_addr, kernel_addr;
   logic [1:0] stride;
   logic busy, row_done, frame_done;
   int total = 0, bad = 0;
   typedef struct {logic [7:0] a, b, c;} col_t;
   typedef struct {logic [3:0] addr; logic [7:0] exp;} kvec_t;
   col_t sb[$];
   kvec_t kt[6];
   conv_line_feeder dut (
      .clk(clk), .rst(rst), .img_wr_en(img_wr_en), .img_wr_addr(img_wr_addr), .img_wr_data(img_wr_data),
      .kw_wr_en(kw_wr_en), .kw_wr_addr(kw_wr_addr), .kw_wr_data(kw_wr_data), .start(start), .stride(stride),
      .shift_buffer(shift_buffer), .kernel_addr(kernel_addr), .in_l1(in_l1), .in_l2(in_l2), .in_l3(in_l3),
      .kernel_in(kernel_in), .busy(busy), .row_done(row_done), .frame_done(frame_done)
   );
   always #5 clk = ~clk;
   task automatic step;
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", n, a, e);
      end
   endtask
   function automatic col_t colx(input int r, input int c);
      col_t x;
      x.a = 8'(r * 16 + c);
      x.b = 8'((r + 1) * 16 + c);
      x.c = 8'((r + 2) * 16 + c);
      return x;
   endfunction
   task automatic chk_col(input string n, input col_t e);
      chk({n, "_l1"}, 32'(in_l1), 32'(e.a));
      chk({n, "_l2"}, 32'(in_l2), 32'(e.b));
      chk({n, "_l3"}, 32'(in_l3), 32'(e.c));
   endtask
   task automatic wr_img(input int a, input logic [7:0] d);
      img_wr_en = 1'b1; img_wr_addr = 6'(a); img_wr_data = d;
      step;
      img_wr_en = 1'b0;
   endtask
   task automatic run_frame(input logic [1:0] st, input int s, input int exp_bands);
      int rb, rd;
      col_t e;
      bit done;
      rb = 0; rd = 0; done = 0;
      sb.push_back(colx(0, 0));
      stride = st; start = 1'b1;
      step;
      start = 1'b0;
      for (int band = 0; band < 8 && !done; band++) begin
         for (int c = 0; c < 8; c++) begin
            e = sb.pop_front();
            chk_col("serve", e);
            chk("serve_busy", 32'(busy), 1);
            chk("serve_row_done", 32'(row_done), 0);
            if (c < 7) sb.push_back(colx(rb, c + 1));
            if (band == 0 && c == 3) begin
               start = 1'b1; img_wr_en = 1'b1; img_wr_addr = 6'd0; img_wr_data = 8'hEE;
            end
            if (s == 2 && band == 0 && c == 2) begin
               kernel_addr = 4'd4; kw_wr_en = 1'b1; kw_wr_addr = 4'd4; kw_wr_data = 8'h55;
               #1;
               chk("kw_old_same_cycle", 32'(kernel_in), 5);
            end
            shift_buffer = 1'b1;
            step;
            shift_buffer = 1'b0; start = 1'b0; img_wr_en = 1'b0;
            if (kw_wr_en) begin
               kw_wr_en = 1'b0;
               chk("kw_new_next_cycle", 32'(kernel_in), 32'h55);
            end
         end
         chk("row_end_pulse", 32'(row_done), 1);
         chk("row_end_no_frame", 32'(frame_done), 0);
         if (row_done) rd++;
         shift_buffer = 1'b1;
         if (rb + s + 2 <= 7) begin
            rb += s;
            sb.push_back(colx(rb, 0));
            step;
            shift_buffer = 1'b0;
         end else begin
            step;
            shift_buffer = 1'b0;
            chk("frame_done_pulse", 32'(frame_done), 1);
            chk("frame_done_busy", 32'(busy), 1);
            step;
            chk("idle_busy", 32'(busy), 0);
            chk("idle_frame_done", 32'(frame_done), 0);
            chk_col("idle_clear", '{8'h00, 8'h00, 8'h00});
            done = 1;
         end
      end
      chk("frame_finished", 32'(done), 1);
      chk("band_count", 32'(rd), 32'(exp_bands));
      sb.delete();
   endtask
   initial begin
      rst = 1'b1; img_wr_en = 1'b0; img_wr_addr = '0; img_wr_data = '0;
      kw_wr_en = 1'b0; kw_wr_addr = '0; kw_wr_data = '0; start = 1'b0; stride = 2'd1;
      shift_buffer = 1'b0; kernel_addr = '0;
      kt[0] = '{4'd0, 8'd1};  kt[1] = '{4'd8, 8'd9};  kt[2] = '{4'd12, 8'd0};
      kt[3] = '{4'd4, 8'd5};  kt[4] = '{4'd15, 8'd0}; kt[5] = '{4'd3, 8'd4};
      step; step;
      chk_col("reset", '{8'h00, 8'h00, 8'h00});
      chk("reset_busy", 32'(busy), 0);
      chk("reset_row_done", 32'(row_done), 0);
      chk("reset_frame_done", 32'(frame_done), 0);
      chk("reset_kernel", 32'(kernel_in), 0);
      rst = 1'b0;
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++) wr_img(r * 8 + c, 8'(r * 16 + c));
      for (int k = 0; k < 9; k++) begin
         kw_wr_en = 1'b1; kw_wr_addr = 4'(k); kw_wr_data = 8'(k + 1);
         step;
      end
      kw_wr_addr = 4'd9; kw_wr_data = 8'hFF;
      step;
      kw_wr_en = 1'b0;
      foreach (kt[i]) begin
         kernel_addr = kt[i].addr;
         step;
         chk($sformatf("kernel_addr_%0d", kt[i].addr), 32'(kernel_in), 32'(kt[i].exp));
      end
      shift_buffer = 1'b1;
      step; step; step;
      shift_buffer = 1'b0;
      chk("idle_shift_busy", 32'(busy), 0);
      chk_col("idle_shift", '{8'h00, 8'h00, 8'h00});
      run_frame(2'd1, 1, 6);
      run_frame(2'd2, 2, 3);
      run_frame(2'd3, 1, 6);
      kernel_addr = 4'd0;
      stride = 2'd1; start = 1'b1;
      step;
      start = 1'b0;
      repeat (3) begin
         shift_buffer = 1'b1;
         step;
      end
      shift_buffer = 1'b0;
      chk_col("mid_band_col3", colx(0, 3));
      rst = 1'b1;
      step;
      rst = 1'b0;
      chk_col("mid_reset", '{8'h00, 8'h00, 8'h00});
      chk("mid_reset_busy", 32'(busy), 0);
      chk("mid_reset_row_done", 32'(row_done), 0);
      chk("mid_reset_frame_done", 32'(frame_done), 0);
      chk("mid_reset_kernel", 32'(kernel_in), 0);
      wr_img(9, 8'h77);
      start = 1'b1; img_wr_en = 1'b1; img_wr_addr = 6'd0; img_wr_data = 8'hAB;
      step;
      start = 1'b0; img_wr_en = 1'b0;
      chk_col("restart", '{8'h00, 8'h10, 8'h20});
      chk("restart_busy", 32'(busy), 1);
      shift_buffer = 1'b1;
      step;
      shift_buffer = 1'b0;
      chk_col("reloaded", '{8'h01, 8'h77, 8'h21});
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
